// File: rtl/lemming_bridge_arbiter.sv
// Round-robin arbiter for a single-lane bridge shared by N lemming walkers.
// Holds each grant for a fixed crossing time and idles for a turnaround before reversing direction.
module lemming_bridge_arbiter #(
    parameter int N            = 4,
    parameter int CROSS_CYCLES = 4,
    parameter int TURN_CYCLES  = 2
) (
    input  logic         clk,
    input  logic         areset,
    input  logic [N-1:0] req,
    input  logic [N-1:0] dir,
    output logic [N-1:0] gnt,
    output logic         busy,
    output logic         bridge_dir,
    output logic         done,
    output logic [3:0]   done_id
);

    localparam int IW = $clog2(N);
    localparam logic [7:0] CROSS_LOAD = 8'(CROSS_CYCLES - 1);
    localparam logic [7:0] TURN_LOAD  = 8'(TURN_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_TURN,
        ST_CROSS
    } state_t;

    state_t         r_state;
    logic [IW-1:0]  r_ptr;
    logic [IW-1:0]  r_win;
    logic [7:0]     r_cnt;
    logic [N-1:0]   r_gnt;
    logic           r_busy;
    logic           r_bridge_dir;
    logic           r_done;
    logic [3:0]     r_done_id;

    state_t         w_state_nxt;
    logic [IW-1:0]  w_ptr_nxt;
    logic [IW-1:0]  w_win_nxt;
    logic [7:0]     w_cnt_nxt;
    logic [N-1:0]   w_gnt_nxt;
    logic           w_bridge_dir_nxt;
    logic           w_done_nxt;
    logic [3:0]     w_done_id_nxt;
    logic           w_found;
    logic [IW-1:0]  w_pick;

    // Index base+off wrapped into 0..N-1 (off < N), valid for non-power-of-two N.
    function automatic logic [IW-1:0] rr_index(input logic [IW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= N) s = s - N;
        return IW'(s);
    endfunction

    function automatic logic [N-1:0] onehot(input logic [IW-1:0] idx);
        logic [N-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // First requesting lemming at or after the round-robin pointer.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        for (int i = 0; i < N; i++) begin
            if (!w_found && req[rr_index(r_ptr, i)]) begin
                w_found = 1'b1;
                w_pick  = rr_index(r_ptr, i);
            end
        end
    end

    // NOTE: every combinational output is given a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        w_state_nxt      = r_state;
        w_ptr_nxt        = r_ptr;
        w_win_nxt        = r_win;
        w_cnt_nxt        = r_cnt;
        w_gnt_nxt        = r_gnt;
        w_bridge_dir_nxt = r_bridge_dir;
        w_done_nxt       = 1'b0;
        w_done_id_nxt    = r_done_id;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_win_nxt = w_pick;
                    if (dir[w_pick] == r_bridge_dir) begin
                        w_state_nxt = ST_CROSS;
                        w_gnt_nxt   = onehot(w_pick);
                        w_cnt_nxt   = CROSS_LOAD;
                    end else begin
                        w_state_nxt = ST_TURN;
                        w_gnt_nxt   = '0;
                        w_cnt_nxt   = TURN_LOAD;
                    end
                end
            end
            ST_TURN: begin
                if (r_cnt == 8'd0) begin
                    w_bridge_dir_nxt = ~r_bridge_dir;
                    w_state_nxt      = ST_CROSS;
                    w_gnt_nxt        = onehot(r_win);
                    w_cnt_nxt        = CROSS_LOAD;
                end else begin
                    w_cnt_nxt = r_cnt - 8'd1;
                end
            end
            ST_CROSS: begin
                if (r_cnt == 8'd0) begin
                    w_state_nxt   = ST_IDLE;
                    w_gnt_nxt     = '0;
                    w_done_nxt    = 1'b1;
                    w_done_id_nxt = 4'(r_win);
                    w_ptr_nxt     = rr_index(r_win, 1);
                end else begin
                    w_cnt_nxt = r_cnt - 8'd1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_gnt_nxt   = '0;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    // NOTE: every register, including the latched winner, is reset so an aborted crossing leaves nothing behind.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            r_state      <= ST_IDLE;
            r_ptr        <= '0;
            r_win        <= '0;
            r_cnt        <= 8'd0;
            r_gnt        <= '0;
            r_busy       <= 1'b0;
            r_bridge_dir <= 1'b0;
            r_done       <= 1'b0;
            r_done_id    <= 4'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_ptr        <= w_ptr_nxt;
            r_win        <= w_win_nxt;
            r_cnt        <= w_cnt_nxt;
            r_gnt        <= w_gnt_nxt;
            r_busy       <= (w_state_nxt != ST_IDLE);
            r_bridge_dir <= w_bridge_dir_nxt;
            r_done       <= w_done_nxt;
            r_done_id    <= w_done_id_nxt;
        end
    end

    assign gnt        = r_gnt;
    assign busy       = r_busy;
    assign bridge_dir = r_bridge_dir;
    assign done       = r_done;
    assign done_id    = r_done_id;

endmodule

// File: doc/lemming_bridge_arbiter.md
Name: lemming_bridge_arbiter

Overview:
- Shares a single-lane bridge between N lemming walker FSMs.
- Each walker raises a request with its walking direction. The block grants the bridge to one walker at a time in round-robin order.
- It holds the grant for a fixed crossing time and inserts a turnaround delay whenever the crossing direction must reverse.
- It sits between the per-lemming walker FSMs and the level/world logic that tracks bridge occupancy.

Parameters:
- N, 4, number of requesting lemmings (legal 2..16).
- CROSS_CYCLES, 4, cycles gnt is held per crossing (legal 1..255).
- TURN_CYCLES, 2, idle cycles inserted before a direction reversal (legal 1..255).

Ports:
- clk  input  1  clock, rising edge.
- areset  input  1  asynchronous reset, active-high.
- req  input  N  per-lemming request; hold high until granted.
- dir  input  N  per-lemming direction: 0 = walking left, 1 = walking right.
- gnt  output  N  one-hot grant; the granted lemming is on the bridge.
- busy  output  1  high whenever the state is not IDLE.
- bridge_dir  output  1  current bridge traffic direction (0 = left, 1 = right).
- done  output  1  one-cycle pulse when a crossing completes.
- done_id  output  4  index of the lemming that just finished; valid while done = 1.

Behaviour:
- Clock and reset: reset areset, asynchronous, active-high; clock clk. All state and outputs are registered.
- Reset values:
  - gnt = 0, busy = 0, bridge_dir = 0 (matches the walker's walk-left reset), done = 0, done_id = 0.
  - Round-robin pointer ptr = 0, 8-bit counter cnt = 0, state = IDLE.
- States: IDLE, TURN, CROSS.
- IDLE:
  - If req == 0, stay in IDLE.
  - Otherwise pick winner w = the first set req bit searching from ptr upward, wrapping at N-1 -> 0.
  - Latch w and dir[w] on that edge.
  - If dir[w] == bridge_dir: go to CROSS, gnt = one-hot(w), cnt = CROSS_CYCLES-1.
  - Else: go to TURN, gnt = 0, cnt = TURN_CYCLES-1.
- TURN:
  - gnt stays 0; decrement cnt each edge.
  - At cnt == 0: toggle bridge_dir, go to CROSS, gnt = one-hot(latched w), cnt = CROSS_CYCLES-1.
- CROSS:
  - Decrement cnt each edge.
  - At cnt == 0: gnt = 0, done = 1, done_id = w, ptr = (w+1) mod N, go to IDLE.
- done is cleared on the next edge. done_id holds its value until the next completion.
- busy = (state != IDLE), registered with the state.
- Latency:
  - Request sampled at edge E0 with the direction matching bridge_dir: gnt is high after E0 through E0+CROSS_CYCLES-1 (exactly CROSS_CYCLES cycles), and done is high after E0+CROSS_CYCLES.
  - Direction mismatch: add TURN_CYCLES. bridge_dir changes together with gnt rising.
  - Back-to-back grants: one-cycle gap (the done cycle), because a new arbitration only happens in IDLE.
- Commitment:
  - The winner and its direction are locked at the IDLE decision.
  - req/dir changes during TURN/CROSS are ignored; a dropped req does not shorten a crossing.
  - A req dropped before it is granted receives no grant.
- Fairness: ptr advances only on completion. With all N requesting continuously, each lemming is granted once per N crossings.
- Simultaneous req edges: only the bits sampled at the IDLE decision edge matter.
- Reset mid-operation: all outputs go to their reset values immediately and asynchronously. No done pulse is produced for the aborted crossing. Arbitration resumes from ptr = 0, bridge_dir = 0.
- gnt is always one-hot or zero. Never more than one bit is set.

Test Plan:
- Reset check: assert areset for 2 cycles with req = 4'b1111 -> gnt = 0, busy = 0, bridge_dir = 0, done = 0, done_id = 0 throughout reset.
- Single left crossing: req = 4'b0010, dir = 0 sampled at E0 -> gnt = 4'b0010 for 4 cycles, busy = 1; after E0+4 gnt = 0, done = 1, done_id = 1 for one cycle; next winner search starts at 2.
- Turnaround: bridge_dir = 0, req = 4'b0100, dir[2] = 1 at E0 -> busy = 1 with gnt = 0 for 2 cycles; after E0+2 bridge_dir = 1 and gnt = 4'b0100 for 4 cycles; done with done_id = 2 after E0+6.
- Round-robin: req = 4'b1111, dir = 0 held -> grant order 0,1,2,3,0; each grant lasts 4 cycles with a 1-cycle done gap; bridge_dir stays 0.
- Dropped request: lemming 3 granted, req[3] deasserted after 1 gnt cycle -> gnt[3] is still held for the full 4 cycles and done_id = 3.
- Async reset in TURN: areset pulsed mid-turn -> gnt = 0, busy = 0, bridge_dir = 0 immediately with no done pulse; then req = 4'b0001, dir = 0 -> gnt = 4'b0001 on the first edge after release.
